// File: rtl/mem_pkg.sv
// Shared definitions for the load/store path: size encodings, size helpers,
// access-unit FSM states and the default RAM depth.
package mem_pkg;

   localparam int MEM_BYTES_DEF = 128;

   localparam logic [1:0] SZ_B  = 2'b00;
   localparam logic [1:0] SZ_H  = 2'b01;
   localparam logic [1:0] SZ_W  = 2'b10;
   localparam logic [1:0] SZ_DW = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } mau_state_e;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_B:    size_bytes = 4'd1;
         SZ_H:    size_bytes = 4'd2;
         SZ_W:    size_bytes = 4'd4;
         SZ_DW:   size_bytes = 4'd8;
         default: size_bytes = 4'd1;
      endcase
   endfunction

   function automatic logic [63:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_B:    size_mask = 64'h0000_0000_0000_00ff;
         SZ_H:    size_mask = 64'h0000_0000_0000_ffff;
         SZ_W:    size_mask = 64'h0000_0000_ffff_ffff;
         SZ_DW:   size_mask = 64'hffff_ffff_ffff_ffff;
         default: size_mask = 64'h0000_0000_0000_00ff;
      endcase
   endfunction

endpackage

// File: rtl/mem_addr_check.sv
// Effective address (base + sign-extended offset, 64-bit wrap) with
// alignment and bounds flags; shared with the instruction fetch path.
module mem_addr_check
   import mem_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF
)(
   input  logic [63:0] base,
   input  logic [15:0] off,
   input  logic [1:0]  size,
   output logic [63:0] ea,
   output logic        misaligned,
   output logic        out_of_bounds
);

   localparam logic [63:0] LIMIT = 64'(MEM_BYTES);

   logic [63:0] sz_s;

   // Both bound terms are kept so huge addresses can never wrap into range
   always_comb begin
      sz_s          = {60'd0, size_bytes(size)};
      ea            = base + {{48{off[15]}}, off};
      misaligned    = (ea & (sz_s - 64'd1)) != 64'd0;
      out_of_bounds = (ea >= LIMIT) || (ea > (LIMIT - sz_s));
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the eBPF execute stage and the bit-indexed
// RAM port: one request at a time, faults answered without touching RAM.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF,
   parameter int FCNT_W    = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic              req_use_imm,
   input  logic [1:0]        req_size,
   input  logic [63:0]       req_base,
   input  logic [15:0]       req_off,
   input  logic [63:0]       req_src,
   input  logic [63:0]       req_imm,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [63:0]       rsp_data,
   output logic              rsp_fault,
   output logic [FCNT_W-1:0] fault_count,
   output logic              mem_load,
   output logic [1:0]        mem_mode,
   output logic [63:0]       mem_madd,
   output logic [63:0]       mem_src,
   output logic [63:0]       mem_imm,
   output logic              mem_slc,
   input  logic [63:0]       mem_rdata
);

   mau_state_e  state_r;
   logic        load_r;
   logic        store_r;
   logic [1:0]  size_r;
   logic [63:0] ea_s;
   logic        misaligned_s;
   logic        oob_s;

   mem_addr_check #(.MEM_BYTES(MEM_BYTES)) u_addr_check (
      .base          (req_base),
      .off           (req_off),
      .size          (req_size),
      .ea            (ea_s),
      .misaligned    (misaligned_s),
      .out_of_bounds (oob_s)
   );

   // A reset landing in ACCESS must suppress the write within that same cycle
   assign mem_load = load_r & ~rst;

   // Request FSM with registered handshake, RAM-port and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_data    <= 64'd0;
         rsp_fault   <= 1'b0;
         fault_count <= '0;
         load_r      <= 1'b0;
         store_r     <= 1'b0;
         size_r      <= SZ_B;
         mem_mode    <= SZ_B;
         mem_madd    <= 64'd0;
         mem_slc     <= 1'b0;
         mem_src     <= 64'd0;
         mem_imm     <= 64'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  if (misaligned_s || oob_s) begin
                     state_r   <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_fault <= 1'b1;
                     rsp_data  <= 64'd0;
                     if (fault_count != '1) begin
                        fault_count <= fault_count + FCNT_W'(1);
                     end
                  end else begin
                     state_r  <= ACCESS;
                     load_r   <= req_store;
                     store_r  <= req_store;
                     size_r   <= req_size;
                     mem_madd <= ea_s << 3;
                     mem_mode <= req_size;
                     mem_slc  <= req_use_imm;
                     mem_src  <= req_src;
                     mem_imm  <= req_imm;
                  end
               end
            end
            ACCESS: begin
               state_r   <= RESP;
               load_r    <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_fault <= 1'b0;
               rsp_data  <= store_r ? 64'd0 : (mem_rdata & size_mask(size_r));
            end
            RESP: begin
               if (rsp_ready) begin
                  state_r   <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state_r   <= IDLE;
               load_r    <= 1'b0;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array RAM, transaction-level reference
// model with a per-cycle compare process, directed and randomized requests.
module tb_mem_access_unit;
   import mem_pkg::*;

   localparam logic [63:0] MEMB = 64'd128;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_store, req_use_imm;
   logic [1:0]  req_size;
   logic [63:0] req_base, req_src, req_imm;
   logic [15:0] req_off;
   logic        rsp_valid, rsp_ready, rsp_fault;
   logic [63:0] rsp_data;
   logic [15:0] fault_count;
   logic        mem_load, mem_slc;
   logic [1:0]  mem_mode;
   logic [63:0] mem_madd, mem_src, mem_imm, mem_rdata;

   // second instance with a narrow counter for the saturation check
   logic        s_req_valid, s_req_ready, s_rsp_valid, s_rsp_fault, s_mem_load, s_mem_slc;
   logic [1:0]  s_mem_mode;
   logic [63:0] s_rsp_data, s_mem_madd, s_mem_src, s_mem_imm;
   logic [3:0]  s_fault_count;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_store(req_store), .req_use_imm(req_use_imm), .req_size(req_size),
      .req_base(req_base), .req_off(req_off), .req_src(req_src), .req_imm(req_imm),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_fault(rsp_fault), .fault_count(fault_count), .mem_load(mem_load),
      .mem_mode(mem_mode), .mem_madd(mem_madd), .mem_src(mem_src),
      .mem_imm(mem_imm), .mem_slc(mem_slc), .mem_rdata(mem_rdata)
   );

   mem_access_unit #(.MEM_BYTES(128), .FCNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
      .req_store(1'b0), .req_use_imm(1'b0), .req_size(SZ_W),
      .req_base(64'd2), .req_off(16'd0), .req_src(64'd0), .req_imm(64'd0),
      .rsp_valid(s_rsp_valid), .rsp_ready(1'b1), .rsp_data(s_rsp_data),
      .rsp_fault(s_rsp_fault), .fault_count(s_fault_count), .mem_load(s_mem_load),
      .mem_mode(s_mem_mode), .mem_madd(s_mem_madd), .mem_src(s_mem_src),
      .mem_imm(s_mem_imm), .mem_slc(s_mem_slc), .mem_rdata(64'd0)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] init_byte(input int i);
      return (i < 2) ? 8'hef : 8'(i * 37 + 11);
   endfunction

   // RAM stand-in driven by the DUT, and the independent reference memory
   logic [7:0] ram [0:127];
   logic [7:0] ref_mem [0:127];
   logic       ram_clr;

   always_comb begin
      logic [63:0] a;
      mem_rdata = 64'd0;
      a = mem_madd >> 3;
      for (int i = 0; i < 8; i++) begin
         if (a + 64'(i) < MEMB) mem_rdata[8*i +: 8] = ram[7'(a + 64'(i))];
      end
   end

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 128; i++) ram[i] <= init_byte(i);
      end else if (mem_load) begin
         for (int i = 0; i < 8; i++) begin
            if (i < (1 << mem_mode) && (mem_madd >> 3) + 64'(i) < MEMB)
               ram[7'((mem_madd >> 3) + 64'(i))] <= 8'((mem_slc ? mem_imm : mem_src) >> (8 * i));
         end
      end
   end

   // expected observable behaviour, stepped by the transaction tasks
   logic        chk_en = 1'b0;
   logic        exp_ready, exp_valid, exp_fault, exp_load, exp_access, exp_slc;
   logic [1:0]  exp_mode;
   logic [63:0] exp_data, exp_madd;
   logic [15:0] exp_fcnt;
   logic [63:0] last_data, last_madd;
   logic        last_fault, last_slc;
   logic [1:0]  last_mode;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", req_ready, exp_ready);
         chk("rsp_valid", rsp_valid, exp_valid);
         chk("mem_load", mem_load, exp_load);
         chk("fault_count", fault_count, exp_fcnt);
         if (exp_valid) begin
            chk("rsp_data", rsp_data, exp_data);
            chk("rsp_fault", rsp_fault, exp_fault);
         end
         if (exp_access) begin
            chk("mem_madd", mem_madd, exp_madd);
            chk("mem_mode", mem_mode, exp_mode);
            chk("mem_slc", mem_slc, exp_slc);
         end
      end
      if (rsp_valid) begin
         last_data  <= rsp_data;
         last_fault <= rsp_fault;
      end
      if (mem_load) begin
         last_madd <= mem_madd;
         last_slc  <= mem_slc;
         last_mode <= mem_mode;
      end
   end

   task automatic set_exp_reset();
      exp_ready = 1'b1; exp_valid = 1'b0; exp_fault = 1'b0; exp_load = 1'b0;
      exp_access = 1'b0; exp_data = 64'd0; exp_fcnt = 16'd0;
   endtask

   task automatic reset_checks();
      chk("rst req_ready", req_ready, 1);
      chk("rst rsp_valid", rsp_valid, 0);
      chk("rst rsp_data", rsp_data, 0);
      chk("rst rsp_fault", rsp_fault, 0);
      chk("rst fault_count", fault_count, 0);
      chk("rst mem_load", mem_load, 0);
      chk("rst mem_mode", mem_mode, 0);
      chk("rst mem_madd", mem_madd, 0);
      chk("rst mem_slc", mem_slc, 0);
      chk("rst mem_src", mem_src, 0);
      chk("rst mem_imm", mem_imm, 0);
   endtask

   // one complete request/response, expectations derived from the access rules
   task automatic xact(input logic st, input logic ui, input logic [1:0] sz,
                       input logic [63:0] base, input logic [15:0] off,
                       input logic [63:0] src, input logic [63:0] imm, input int hold);
      logic [63:0] ea, nb, d, wd;
      logic        flt;
      nb  = 64'd1 << sz;
      ea  = base + {{48{off[15]}}, off};
      flt = (ea % nb != 64'd0) || (ea >= MEMB) || (ea > MEMB - nb);
      d   = 64'd0;
      wd  = ui ? imm : src;
      if (!flt) begin
         for (int i = 0; i < int'(nb); i++) begin
            if (st) ref_mem[int'(ea) + i] = 8'(wd >> (8 * i));
            else    d = d | (64'(ref_mem[int'(ea) + i]) << (8 * i));
         end
      end
      @(negedge clk);
      req_store = st; req_use_imm = ui; req_size = sz; req_base = base;
      req_off = off; req_src = src; req_imm = imm; req_valid = 1'b1;
      rsp_ready = (hold == 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      exp_ready = 1'b0;
      if (flt) begin
         exp_valid = 1'b1; exp_fault = 1'b1; exp_data = 64'd0;
         if (exp_fcnt != 16'hffff) exp_fcnt = exp_fcnt + 16'd1;
      end else begin
         exp_load = st; exp_access = 1'b1;
         exp_madd = ea * 64'd8; exp_mode = sz; exp_slc = ui;
         @(posedge clk); #1;
         exp_load = 1'b0; exp_access = 1'b0;
         exp_valid = 1'b1; exp_fault = 1'b0; exp_data = st ? 64'd0 : d;
      end
      repeat (hold) @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      exp_valid = 1'b0;
      exp_ready = 1'b1;
   endtask

   task automatic rst_during_store(input logic [63:0] imm);
      @(negedge clk);
      req_store = 1'b1; req_use_imm = 1'b1; req_size = SZ_DW; req_base = 64'd0;
      req_off = 16'd0; req_imm = imm; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk_en = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("load gated by rst", mem_load, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      reset_checks();
      set_exp_reset();
      chk_en = 1'b1;
   endtask

   initial begin
      logic [63:0] b, s, m;
      logic [15:0] o;
      rst = 1'b1; ram_clr = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_store = 1'b0; req_use_imm = 1'b0; req_size = SZ_B; req_base = 64'd0;
      req_off = 16'd0; req_src = 64'd0; req_imm = 64'd0; s_req_valid = 1'b0;
      for (int i = 0; i < 128; i++) ref_mem[i] = init_byte(i);
      set_exp_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; ram_clr = 1'b0;
      @(negedge clk);
      reset_checks();
      chk_en = 1'b1;

      xact(0, 0, SZ_B, 64'd0, 16'd0, 64'd0, 64'd0, 0);
      chk("ldb data", last_data, 64'h0000_0000_0000_00ef);
      chk("ldb fault", last_fault, 0);
      xact(0, 0, SZ_H, 64'd0, 16'd0, 64'd0, 64'd0, 0);
      chk("ldh data", last_data, 64'h0000_0000_0000_efef);
      xact(1, 1, SZ_DW, 64'd8, 16'd0, 64'h5555_aaaa_5555_aaaa, 64'h0123_4567_89ab_cdef, 0);
      chk("st madd", last_madd, 64'd64);
      chk("st slc", last_slc, 1);
      chk("st mode", last_mode, 3);
      xact(0, 0, SZ_DW, 64'd16, 16'hfff8, 64'd0, 64'd0, 0);
      chk("lddw data", last_data, 64'h0123_4567_89ab_cdef);
      xact(0, 0, SZ_W, 64'd2, 16'd0, 64'd0, 64'd0, 0);
      chk("misaligned fault", last_fault, 1);
      chk("misaligned data", last_data, 64'd0);
      chk("fault_count one", fault_count, 16'd1);
      xact(0, 0, SZ_DW, 64'd120, 16'd0, 64'd0, 64'd0, 0);
      chk("dw@120 fault", last_fault, 0);
      xact(0, 0, SZ_DW, 64'd128, 16'd0, 64'd0, 64'd0, 0);
      chk("dw@128 fault", last_fault, 1);
      xact(0, 0, SZ_DW, 64'hffff_ffff_ffff_fff8, 16'd0, 64'd0, 64'd0, 1);
      chk("dw@-8 fault", last_fault, 1);
      chk("fault_count three", fault_count, 16'd3);
      xact(0, 0, SZ_W, 64'd4, 16'd0, 64'd0, 64'd0, 5);

      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 9))
            7:       b = {$urandom, $urandom};
            8:       b = 64'hffff_ffff_ffff_fff0 + 64'($urandom_range(0, 15));
            default: b = 64'($urandom_range(0, 140));
         endcase
         o = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 32)) - 16'd16;
         if ($urandom_range(0, 1) == 1) begin
            b = b & ~64'd7;
            o = o & ~16'd7;
         end
         s = {$urandom, $urandom};
         m = {$urandom, $urandom};
         xact(1'($urandom), 1'($urandom), 2'($urandom), b, o, s, m,
              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      end

      rst_during_store(64'hdead_beef_cafe_f00d);
      xact(0, 0, SZ_DW, 64'd0, 16'd0, 64'd0, 64'd0, 0);
      chk("no write under rst", (last_data == 64'hdead_beef_cafe_f00d) ? 64'd1 : 64'd0, 64'd0);

      chk_en = 1'b0;
      @(negedge clk);
      s_req_valid = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("sat progress", s_fault_count, 4'd3);
      repeat (34) @(posedge clk);
      @(negedge clk);
      chk("sat count", s_fault_count, 4'hf);
      s_req_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
